// File: rtl/loop_ctrl_fsm.sv
// Counted-loop controller: for (i = 0; i < bound; i += step) with an II-spaced
// issue strobe, LAT-cycle body drain after the final issue, then a done pulse.
module loop_ctrl_fsm #(
  parameter int WIDTH = 4,
  parameter int II    = 1,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bound,
  input  logic [WIDTH-1:0] step,
  input  logic             stall,
  output logic             busy,
  output logic             iter_valid,
  output logic [WIDTH-1:0] iter_idx,
  output logic             iter_last,
  output logic             done
);

  localparam int IIW   = (II > 1) ? $clog2(II) : 1;
  localparam int DLAST = (LAT > 0) ? LAT - 1 : 0;
  localparam int DW    = (DLAST > 0) ? $clog2(DLAST + 1) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] i_q, i_nxt;
  logic [WIDTH-1:0] bound_q, bound_nxt;
  logic [WIDTH-1:0] step_q, step_nxt;
  logic [IIW-1:0]   ii_q, ii_nxt;
  logic [DW-1:0]    dc_q, dc_nxt;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             issue;

  // One extra bit so an index overflow counts as "past the bound", never a wrap.
  assign sum   = {1'b0, i_q} + {1'b0, step_q};
  assign last  = (sum >= {1'b0, bound_q});
  assign issue = (state == RUN) && (ii_q == '0) && !stall;

  assign busy       = (state != IDLE);
  assign iter_valid = issue;
  assign iter_idx   = issue ? i_q : '0;
  assign iter_last  = issue && last;
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      i_q     <= '0;
      bound_q <= '0;
      step_q  <= '0;
      ii_q    <= '0;
      dc_q    <= '0;
    end else begin
      state   <= state_nxt;
      i_q     <= i_nxt;
      bound_q <= bound_nxt;
      step_q  <= step_nxt;
      ii_q    <= ii_nxt;
      dc_q    <= dc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    bound_nxt = bound_q;
    step_nxt  = step_q;
    ii_nxt    = ii_q;
    dc_nxt    = dc_q;
    case (state)
      IDLE: begin
        if (start) begin
          bound_nxt = bound;
          step_nxt  = (step == '0) ? WIDTH'(1) : step;
          state_nxt = INIT;
        end
      end
      INIT: begin
        i_nxt     = '0;
        ii_nxt    = '0;
        dc_nxt    = '0;
        state_nxt = (bound_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (!stall) begin
          if (ii_q == '0) begin
            if (last) begin
              // Trailing II-1 slots are skipped; drain starts right away.
              state_nxt = (LAT > 0) ? DRAIN : DONE;
            end else begin
              i_nxt  = sum[WIDTH-1:0];
              ii_nxt = IIW'((II > 1) ? 1 : 0);
            end
          end else begin
            ii_nxt = (ii_q == IIW'(II - 1)) ? '0 : ii_q + IIW'(1);
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (dc_q == DW'(DLAST)) state_nxt = DONE;
          else                    dc_nxt    = dc_q + DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_loop_ctrl_fsm.sv
// Scoreboard bench: two instances (II=1/LAT=2 and II=3/LAT=0), expected issues
// and done pulses are queued from a timing model and checked as they appear.
module tb_loop_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [3:0] bound_a = '0, step_a = '0, bound_b = '0, step_b = '0;
  logic       busy_a, iter_valid_a, iter_last_a, done_a;
  logic       busy_b, iter_valid_b, iter_last_b, done_b;
  logic [3:0] iter_idx_a, iter_idx_b;

  loop_ctrl_fsm #(.WIDTH(4), .II(1), .LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bound(bound_a), .step(step_a),
    .stall(stall_a), .busy(busy_a), .iter_valid(iter_valid_a),
    .iter_idx(iter_idx_a), .iter_last(iter_last_a), .done(done_a)
  );

  loop_ctrl_fsm #(.WIDTH(4), .II(3), .LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bound(bound_b), .step(step_b),
    .stall(stall_b), .busy(busy_b), .iter_valid(iter_valid_b),
    .iter_idx(iter_idx_b), .iter_last(iter_last_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int cyc;
    int idx;
    bit last;
  } it_t;

  it_t iq_a[$], iq_b[$];
  int  dq_a[$], dq_b[$];
  it_t e_a, e_b;

  // Monitors sample 1 time unit after the falling edge, after any stimulus change.
  always @(negedge clk) begin
    #1;
    if (iq_a.size() > 0 && iq_a[0].cyc < cyc) begin
      vectors++; errors++;
      $display("FAIL iter_a_missing cyc=%0d exp_idx=%0d exp_cyc=%0d", cyc, iq_a[0].idx, iq_a[0].cyc);
      void'(iq_a.pop_front());
    end
    if (iter_valid_a) begin
      vectors++;
      if (iq_a.size() == 0) begin
        errors++;
        $display("FAIL iter_a_unexpected cyc=%0d got_idx=%0d", cyc, iter_idx_a);
      end else begin
        e_a = iq_a.pop_front();
        if (e_a.cyc !== cyc || e_a.idx !== int'(iter_idx_a) || e_a.last !== iter_last_a) begin
          errors++;
          $display("FAIL iter_a got cyc=%0d idx=%0d last=%0b exp cyc=%0d idx=%0d last=%0b",
                   cyc, iter_idx_a, iter_last_a, e_a.cyc, e_a.idx, e_a.last);
        end
      end
    end
    if (dq_a.size() > 0 && dq_a[0] < cyc) begin
      vectors++; errors++;
      $display("FAIL done_a_missing cyc=%0d exp_cyc=%0d", cyc, dq_a[0]);
      void'(dq_a.pop_front());
    end
    if (done_a) begin
      vectors++;
      if (dq_a.size() == 0) begin
        errors++;
        $display("FAIL done_a_unexpected cyc=%0d", cyc);
      end else if (dq_a.pop_front() !== cyc) begin
        errors++;
        $display("FAIL done_a_cycle got cyc=%0d", cyc);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (iq_b.size() > 0 && iq_b[0].cyc < cyc) begin
      vectors++; errors++;
      $display("FAIL iter_b_missing cyc=%0d exp_idx=%0d exp_cyc=%0d", cyc, iq_b[0].idx, iq_b[0].cyc);
      void'(iq_b.pop_front());
    end
    if (iter_valid_b) begin
      vectors++;
      if (iq_b.size() == 0) begin
        errors++;
        $display("FAIL iter_b_unexpected cyc=%0d got_idx=%0d", cyc, iter_idx_b);
      end else begin
        e_b = iq_b.pop_front();
        if (e_b.cyc !== cyc || e_b.idx !== int'(iter_idx_b) || e_b.last !== iter_last_b) begin
          errors++;
          $display("FAIL iter_b got cyc=%0d idx=%0d last=%0b exp cyc=%0d idx=%0d last=%0b",
                   cyc, iter_idx_b, iter_last_b, e_b.cyc, e_b.idx, e_b.last);
        end
      end
    end
    if (dq_b.size() > 0 && dq_b[0] < cyc) begin
      vectors++; errors++;
      $display("FAIL done_b_missing cyc=%0d exp_cyc=%0d", cyc, dq_b[0]);
      void'(dq_b.pop_front());
    end
    if (done_b) begin
      vectors++;
      if (dq_b.size() == 0) begin
        errors++;
        $display("FAIL done_b_unexpected cyc=%0d", cyc);
      end else if (dq_b.pop_front() !== cyc) begin
        errors++;
        $display("FAIL done_b_cycle got cyc=%0d", cyc);
      end
    end
  end

  // Timing model: cycle n after the accepting edge is absolute cycle base+n-1.
  task automatic model(input int sel, input int base, input int bnd, input int stp);
    int s, i, k, ii, lat;
    it_t e;
    ii  = sel ? 3 : 1;
    lat = sel ? 0 : 2;
    s   = (stp == 0) ? 1 : stp;
    if (bnd == 0) begin
      if (sel) dq_b.push_back(base + 1); else dq_a.push_back(base + 1);
      return;
    end
    i = 0;
    k = 0;
    forever begin
      e.cyc  = base + 1 + k * ii;
      e.idx  = i;
      e.last = (i + s >= bnd);
      if (sel) iq_b.push_back(e); else iq_a.push_back(e);
      if (e.last) break;
      i += s;
      k++;
    end
    if (sel) dq_b.push_back(base + 2 + k * ii + lat);
    else     dq_a.push_back(base + 2 + k * ii + lat);
  endtask

  // Called at a falling edge; raises start for one edge and returns at the next falling edge.
  task automatic go(input int sel, input int bnd, input int stp, input bit push);
    if (sel) begin bound_b = 4'(bnd); step_b = 4'(stp); start_b = 1'b1; end
    else     begin bound_a = 4'(bnd); step_a = 4'(stp); start_a = 1'b1; end
    if (push) model(sel, cyc + 1, bnd, stp);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    bound_a = 4'($urandom); step_a = 4'($urandom);
    bound_b = 4'($urandom); step_b = 4'($urandom);
  endtask

  task automatic wait_idle(input int sel);
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      #2;
      if (sel) ok = (iq_b.size() == 0) && (dq_b.size() == 0) && !busy_b;
      else     ok = (iq_a.size() == 0) && (dq_a.size() == 0) && !busy_a;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle_%0d timeout cyc=%0d got busy=%0b exp busy=0", sel, cyc, sel ? busy_b : busy_a);
      iq_a.delete(); iq_b.delete(); dq_a.delete(); dq_b.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy_a, iter_valid_a, iter_idx_a, iter_last_a, done_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a got=%h exp=00", {busy_a, iter_valid_a, iter_idx_a, iter_last_a, done_a});
    end
    vectors++;
    if ({busy_b, iter_valid_b, iter_idx_b, iter_last_b, done_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b got=%h exp=00", {busy_b, iter_valid_b, iter_idx_b, iter_last_b, done_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%0b exp=0", busy_a); end
  endtask

  task automatic test_basic();
    go(0, 3, 1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      vectors++;
      if (busy_a !== (k <= 7)) begin
        errors++;
        $display("FAIL basic_busy cycle=%0d got=%0b exp=%0b", k, busy_a, k <= 7);
      end
    end
    wait_idle(0);
  endtask

  task automatic test_ii3();
    @(negedge clk);
    go(1, 5, 2, 1'b1);
    wait_idle(1);
  endtask

  task automatic test_carry();
    @(negedge clk);
    go(0, 15, 6, 1'b1);
    wait_idle(0);
    @(negedge clk);
    go(0, 3, 0, 1'b1);
    wait_idle(0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    go(0, 0, 5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_cycle3 got busy=%0b exp=0", busy_a); end
    go(0, 2, 1, 1'b1);
    wait_idle(0);
  endtask

  task automatic test_stall();
    it_t e;
    int base;
    @(negedge clk);
    base = cyc + 1;
    e.cyc = base + 1; e.idx = 0; e.last = 1'b0; iq_a.push_back(e);
    e.cyc = base + 4; e.idx = 1; e.last = 1'b0; iq_a.push_back(e);
    e.cyc = base + 5; e.idx = 2; e.last = 1'b0; iq_a.push_back(e);
    e.cyc = base + 6; e.idx = 3; e.last = 1'b1; iq_a.push_back(e);
    dq_a.push_back(base + 10);
    go(0, 4, 1, 1'b0);
    for (int c = 2; c <= 13; c++) begin
      @(negedge clk);
      case (c)
        3:  stall_a = 1'b1;
        5:  begin stall_a = 1'b0; start_a = 1'b1; bound_a = 4'd9; end
        6:  start_a = 1'b0;
        9:  stall_a = 1'b1;
        10: stall_a = 1'b0;
        11: start_a = 1'b1;
        12: start_a = 1'b0;
        default: ;
      endcase
      if (c >= 12) begin
        vectors++;
        if (busy_a !== 1'b0) begin
          errors++;
          $display("FAIL stall_start_in_done cycle=%0d got busy=%0b exp=0", c, busy_a);
        end
      end
    end
    wait_idle(0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    go(0, 8, 1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    iq_a.delete();
    dq_a.delete();
    #1;
    vectors++;
    if ({busy_a, iter_valid_a, iter_idx_a, iter_last_a, done_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=00", {busy_a, iter_valid_a, iter_idx_a, iter_last_a, done_a});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(0, 2, 1, 1'b1);
    wait_idle(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ii3();
    test_carry();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/loop_ctrl_fsm.md
# loop_ctrl_fsm

Parametrised controller for a single counted HLS loop: `for (i = 0; i < bound; i += step)`. Accepts a start request, issues one iteration strobe with its index every II cycles, drains the loop-body pipeline for LAT cycles after the final issue, then pulses done. It is the generic replacement for hand-written per-loop state machines: one instance per loop in the generated datapath, with runtime bound/step, back-pressure and a last-iteration flag.

## Interface
- WIDTH, 4, bit width of loop index, bound and step
- II, 1, initiation interval in cycles (≥1)
- LAT, 2, body pipeline latency drained after the last issue (≥0)

- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  request loop execution; sampled only in IDLE
- bound  input  WIDTH  exclusive upper bound; latched on accepted start
- step  input  WIDTH  index increment; latched on accepted start; 0 treated as 1
- stall  input  1  freezes RUN/DRAIN progress while high
- busy  output  1  high in every state except IDLE
- iter_valid  output  1  iteration issued this cycle
- iter_idx  output  WIDTH  index of issued iteration; valid with iter_valid
- iter_last  output  1  issued iteration is the final one; valid with iter_valid
- done  output  1  one-cycle pulse on loop completion

## Operation
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE: start=1 → latch bound, step (step=0 → 1); go INIT. Otherwise stay.
- INIT: i←0, ii_cnt←0, drain_cnt←0; bound=0 → DONE (no iterations, no drain); else → RUN.
- RUN: issue when ii_cnt==0 and stall=0: iter_valid=1, iter_idx=i. Next index = i+step computed in WIDTH+1 bits; last = (sum ≥ bound) or carry out. On last issue: LAT>0 → DRAIN, LAT=0 → DONE; remaining II-1 slots are not waited. Otherwise i←i+step, ii_cnt←(II==1 ? 0 : 1). When ii_cnt≠0 and stall=0, ii_cnt←(ii_cnt+1) mod II.
- DRAIN: drain_cnt increments when stall=0; after LAT unstalled cycles → DONE.
- DONE: done=1 for exactly one cycle; → IDLE unconditionally. start in DONE is ignored.
- stall=1 in RUN/DRAIN: i, ii_cnt, drain_cnt, state frozen; iter_valid=0. stall ignored in IDLE, INIT, DONE.
- start while busy is ignored; bound/step changes after acceptance have no effect.
- iter_valid, iter_last, done are combinational decodes of registered state only (no input-to-output path except stall gating iter_valid).

## Timing
- Reset (rst_n=0, any time incl. mid-loop): state=IDLE, i=0, counters=0 immediately; busy=0, iter_valid=0, iter_idx=0, iter_last=0, done=0. Release synchronously de-asserted by the system.
- Start accepted at edge E0: cycle 1 INIT (busy=1), first iteration (idx 0) in cycle 2.
- Without stalls, N≥1 iterations: issue k in cycle 2+k·II; done high in cycle 3+(N−1)·II+LAT; IDLE the cycle after. N=0: done in cycle 2.
- Each stalled cycle in RUN/DRAIN delays all later events by one cycle.
- Earliest restart: start sampled in the first IDLE cycle after done.

## Test plan
- WIDTH=4, II=1, LAT=2, bound=3, step=1, start at E0 → iter_valid cycles 2,3,4 with idx 0,1,2, iter_last only in cycle 4; done only in cycle 7; busy cycles 1–7.
- II=3, LAT=0, bound=5, step=2 → idx 0,2,4 in cycles 2,5,8; iter_last in cycle 8; done in cycle 9.
- WIDTH=4, bound=15, step=6 → idx 0,6,12; 12+6 carries out → iter_last on idx 12; no wrap to 2. Also step=0 → behaves as step=1.
- bound=0 → no iter_valid; done in cycle 2; back-to-back start in cycle 3 accepted.
- II=1, LAT=2, bound=4; stall high for cycles 3–4 and one DRAIN cycle → idx 0 in cycle 2, idx 1 in cycle 5, no issues while stalled, done in cycle 11; start pulses while busy ignored.
- rst_n low in mid-RUN (after idx 1) → all outputs 0 immediately, no done; after release, new start runs from idx 0 with fresh bound.
